pc_unit: RTL
============

Name: pc_unit

Overview:
- Parametrised program-counter unit for the pipelined core; successor to the fixed 32-bit/16-bit PC block.
- Generalises PC width, memory-data width and vectors.
- Adds a multi-beat return-address load FSM, pending-interrupt latching with saved PC (epc), stall hold and a programmable rewind distance.
- Sits in fetch; driven by decode (call), execute (branch), memory stage (RET data) and the interrupt controller.

Parameters:
- PC_W, 32, PC register width; must be a multiple of DATA_W.
- DATA_W, 16, memory/ALU/register data width.
- RESET_VEC, 32, PC value loaded on reset.
- INT_VEC, 0, interrupt handler entry address.
- REWIND, 2, distance subtracted on a rewind request.
- BEATS, PC_W/DATA_W, derived localparam: RET load beats.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold PC and FSM; reset still acts.
- int_req  in  1  interrupt request (level or pulse); latched into int_pend.
- int_ack  out  1  one-cycle pulse when interrupt is taken.
- epc  out  PC_W  PC value at interrupt acceptance.
- call_valid  in  1  call redirect request.
- call_target  in  DATA_W  call target, zero-extended.
- ret_start  in  1  begin RET return-address load.
- mem_valid  in  1  mem_data holds the next RET beat.
- mem_data  in  DATA_W  RET beat, most-significant slice first.
- br_taken  in  1  branch redirect request.
- br_target  in  DATA_W  branch target, zero-extended.
- rewind  in  1  pc <= pc - REWIND.
- pc  out  PC_W  current program counter.
- busy  out  1  high while FSM is in RET_LOAD.
- ret_done  out  1  one-cycle pulse when the last RET beat is written.

Behaviour:
- Reset values: pc=RESET_VEC, epc=0, state=RUN, beat counter=BEATS-1, int_pend=0, int_ack=0, ret_done=0.
- Reset overrides every other input in the same cycle.
- int_pend is set when int_req=1 and cleared on acceptance. A request arriving while int_pend=1 merges into the pending one.
- FSM states: RUN and RET_LOAD.
- RUN priority, evaluated when stall=0:
  1. int_pend or int_req: epc<=pc, pc<=INT_VEC, int_ack=1.
  2. call_valid: pc<={0,call_target}.
  3. ret_start: enter RET_LOAD, beat counter=BEATS-1, pc holds.
  4. br_taken: pc<={0,br_target}.
  5. rewind: pc<=pc-REWIND, modulo 2^PC_W.
  6. Otherwise: pc<=pc+1, wrapping all-ones to 0.
- RET_LOAD:
  - Each cycle with mem_valid=1 and stall=0 writes mem_data into pc slice [cnt*DATA_W +: DATA_W], then decrements cnt.
  - mem_valid=0 holds pc and cnt with no timeout.
  - On the beat with cnt=0: ret_done=1 and the next state is RUN. pc holds the loaded value that cycle and increments from the following cycle.
  - call_valid, ret_start, br_taken and rewind are ignored in RET_LOAD.
  - int_req is latched into int_pend and taken in the first RUN cycle after ret_done, so epc holds the full return address.
- stall=1: pc, state, cnt and epc hold. int_req is still latched. Pulses (int_ack, ret_done) are 0.
- busy=1 exactly while state=RET_LOAD.
- Reset during RET_LOAD aborts the load: pc=RESET_VEC and any partial slices are discarded.
- Simultaneous int and call in RUN: the interrupt wins and the call is dropped; upstream flushes on int_ack.
- BEATS=1 is legal: RET_LOAD lasts exactly one valid beat.

Decomposition:
- Shared core package holds:
  - PC_W and DATA_W defaults;
  - RESET_VEC and INT_VEC constants;
  - FSM state enum {RUN, RET_LOAD};
  - redirect-source encoding, reused by hazard and debug logic.
- One natural sub-module: pc_ret_loader, containing the beat counter, slice write-enable decode and ret_done generation.

Test Plan:
- Reset, then 3 idle cycles -> pc=32, 33, 34, 35; busy=0; int_ack=0.
- pc=40, br_taken with br_target=0x0100 -> pc=0x100, then 0x101. Next, rewind at 0x101 -> pc=0xFF.
- pc=50, ret_start; mem_data 0x0001 (valid), one idle cycle, 0x2345 (valid) -> busy for 3 cycles; pc=0x00012345; ret_done pulses; next cycle pc=0x00012346.
- int_req during RET_LOAD second beat -> int_ack is 0 until the cycle after ret_done; then epc=0x00012345 and pc=0.
- Same cycle int_req and call_valid (call_target=0x80) at pc=60 -> pc=0, epc=60, int_ack=1; the call is dropped.
- pc=0xFFFFFFFF idle -> pc=0. Separately, reset asserted mid-RET_LOAD -> pc=32, busy=0, no ret_done.

Source files
------------

// File: rtl/pc_unit_pkg.sv
// Shared definitions for the fetch-stage program-counter unit.
// Holds default widths and vectors, the FSM state type, and the
// redirect-source encoding also consumed by hazard and debug logic.
package pc_unit_pkg;

    localparam int unsigned PC_W_DEF      = 32;
    localparam int unsigned DATA_W_DEF    = 16;
    localparam int unsigned RESET_VEC_DEF = 32;
    localparam int unsigned INT_VEC_DEF   = 0;
    localparam int unsigned REWIND_DEF    = 2;

    typedef enum logic {
        RUN      = 1'b0,
        RET_LOAD = 1'b1
    } pc_state_e;

    // Which source updates the PC in a given cycle.
    typedef enum logic [2:0] {
        SRC_HOLD   = 3'd0,
        SRC_INT    = 3'd1,
        SRC_CALL   = 3'd2,
        SRC_RET    = 3'd3,
        SRC_BR     = 3'd4,
        SRC_REWIND = 3'd5,
        SRC_SEQ    = 3'd6,
        SRC_LOAD   = 3'd7
    } redirect_e;

    // Beat counter width; a single-beat load still needs a 1-bit counter.
    function automatic int unsigned cnt_width(input int unsigned beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/pc_ret_loader.sv
// Return-address beat sequencer for the PC unit.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   stall           freezes the counter; suppresses beats
//   start           load begins this cycle (counter re-armed)
//   active          FSM is in RET_LOAD
//   mem_valid       a return-address beat is present
//   slice_we_c      one-hot PC slice write enable (combinational)
//   last_c          final beat is being written (combinational)
//   ret_done        registered pulse after the final beat
module pc_ret_loader
    import pc_unit_pkg::*;
#(
    parameter int unsigned BEATS = 2,
    parameter int unsigned CNT_W = cnt_width(BEATS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             start,
    input  logic             active,
    input  logic             mem_valid,
    output logic [BEATS-1:0] slice_we_c,
    output logic             last_c,
    output logic             ret_done
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(BEATS - 1);

    logic [CNT_W-1:0] cnt;
    logic             beat_c;

    // A beat is consumed only while loading, with data present and no stall.
    assign beat_c = active & mem_valid & ~stall;
    assign last_c = beat_c & (cnt == '0);

    // Beats arrive most-significant slice first; cnt names the slice.
    always_comb begin
        slice_we_c = '0;
        for (int i = 0; i < int'(BEATS); i++) begin
            if (beat_c && (cnt == CNT_W'(i))) begin
                slice_we_c[i] = 1'b1;
            end
        end
    end

    // Counter re-arms on start and after the final beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= CNT_INIT;
            ret_done <= 1'b0;
        end else begin
            ret_done <= last_c;
            if (start || last_c) begin
                cnt <= CNT_INIT;
            end else if (beat_c) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter with interrupt entry, call/branch
// redirects, rewind and a multi-beat return-address load.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   stall                      hold PC/FSM/epc; interrupts still latch
//   int_req / int_ack / epc    interrupt request, taken pulse, saved PC
//   call_valid, call_target    call redirect (zero-extended)
//   ret_start, mem_valid, mem_data   return-address load, MS slice first
//   br_taken, br_target        branch redirect (zero-extended)
//   rewind                     pc <= pc - REWIND
//   pc, busy, ret_done         PC, load in progress, load-complete pulse
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int unsigned      PC_W      = PC_W_DEF,
    parameter int unsigned      DATA_W    = DATA_W_DEF,
    parameter logic [PC_W-1:0]  RESET_VEC = PC_W'(RESET_VEC_DEF),
    parameter logic [PC_W-1:0]  INT_VEC   = PC_W'(INT_VEC_DEF),
    parameter logic [PC_W-1:0]  REWIND    = PC_W'(REWIND_DEF)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              int_req,
    output logic              int_ack,
    output logic [PC_W-1:0]   epc,
    input  logic              call_valid,
    input  logic [DATA_W-1:0] call_target,
    input  logic              ret_start,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              br_taken,
    input  logic [DATA_W-1:0] br_target,
    input  logic              rewind,
    output logic [PC_W-1:0]   pc,
    output logic              busy,
    output logic              ret_done
);

    localparam int unsigned BEATS = PC_W / DATA_W;

    pc_state_e        state;
    pc_state_e        state_next;
    redirect_e        src_c;
    logic [PC_W-1:0]  pc_next;
    logic [PC_W-1:0]  epc_next;
    logic             int_pend;
    logic             int_pend_next;
    logic             int_ack_next;
    logic             ret_start_c;
    logic [BEATS-1:0] slice_we_c;
    logic             last_c;

    pc_ret_loader #(
        .BEATS (BEATS)
    ) u_ret_loader (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .start      (ret_start_c),
        .active     (state == RET_LOAD),
        .mem_valid  (mem_valid),
        .slice_we_c (slice_we_c),
        .last_c     (last_c),
        .ret_done   (ret_done)
    );

    assign busy = (state == RET_LOAD);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Redirect selection, next state and next datapath values.
    always_comb begin
        state_next    = state;
        src_c         = SRC_HOLD;
        pc_next       = pc;
        epc_next      = epc;
        int_ack_next  = 1'b0;
        ret_start_c   = 1'b0;
        int_pend_next = int_pend | int_req;

        if (!stall) begin
            if (state == RUN) begin
                if (int_pend || int_req) begin
                    src_c = SRC_INT;
                end else if (call_valid) begin
                    src_c = SRC_CALL;
                end else if (ret_start) begin
                    src_c = SRC_RET;
                end else if (br_taken) begin
                    src_c = SRC_BR;
                end else if (rewind) begin
                    src_c = SRC_REWIND;
                end else begin
                    src_c = SRC_SEQ;
                end
            end else begin
                // Interrupts stay pending until the load finishes so epc
                // captures the complete return address.
                if (|slice_we_c) begin
                    src_c = SRC_LOAD;
                end
                if (last_c) begin
                    state_next = RUN;
                end
            end
        end

        case (src_c)
            SRC_INT: begin
                epc_next      = pc;
                pc_next       = INT_VEC;
                int_ack_next  = 1'b1;
                int_pend_next = 1'b0;
            end
            SRC_CALL:   pc_next = PC_W'(call_target);
            SRC_RET: begin
                state_next  = RET_LOAD;
                ret_start_c = 1'b1;
            end
            SRC_BR:     pc_next = PC_W'(br_target);
            SRC_REWIND: pc_next = pc - REWIND;
            SRC_SEQ:    pc_next = pc + PC_W'(1);
            SRC_LOAD: begin
                for (int i = 0; i < int'(BEATS); i++) begin
                    if (slice_we_c[i]) begin
                        pc_next[i*DATA_W +: DATA_W] = mem_data;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_VEC;
            epc      <= '0;
            int_pend <= 1'b0;
            int_ack  <= 1'b0;
        end else begin
            pc       <= pc_next;
            epc      <= epc_next;
            int_pend <= int_pend_next;
            int_ack  <= int_ack_next;
        end
    end

endmodule
